hdmi_cfg_sequencer: RTL and testbench

Sequences the HDMI transmitter's I2C register configuration after power-up and on hot-plug events. It walks a constant table of (register, value) write pairs and hands each one to a byte-level I2C write master over a valid/ready command and response handshake. It retries NACKed writes and reports ready/fail status to the LEDs and the top level. It sits between the top-level reset latch and the I2C write master that drives the SCL/SDA pins.

---
 rtl/hdmi_cfg_pkg.sv | 43 ++++
 rtl/hdmi_cfg_rom.sv | 28 ++
 rtl/hdmi_cfg_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_hdmi_cfg_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_cfg_pkg.sv
// rtl/hdmi_cfg_pkg.sv - shared types and constants for the HDMI config sequencer
//
// Purpose: state encoding, default transmitter I2C address and the
//          {reg, value} configuration table walked by the sequencer.
// Ports:   none (package).
package hdmi_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PWR_WAIT,
        ISSUE,
        WAIT_RSP,
        GAP,
        DONE,
        FAIL
    } cfg_state_t;

    localparam logic [7:0] DEFAULT_DEV_ADDR = 8'h72;

    localparam int CFG_TABLE_LEN = 16;

    // Entry i lives at bits [i*16 +: 16] as {reg, value}; entry 0 is the
    // rightmost element of the concatenation.
    localparam logic [CFG_TABLE_LEN*16-1:0] CFG_TABLE = {
        16'h5510,   // 15: AVI infoframe, RGB output
        16'h4080,   // 14: enable general control packet
        16'hAF06,   // 13: HDMI mode, HDCP off
        16'h1846,   // 12: colour space converter disabled
        16'h1702,   // 11: 16:9 aspect, sync polarity from input
        16'h1630,   // 10: 8-bit 4:4:4 input style
        16'h1500,   //  9: input ID 0, 4:4:4 RGB
        16'hF900,   //  8: fixed register
        16'hE0D0,   //  7: fixed register
        16'hA3A4,   //  6: fixed register
        16'hA2A4,   //  5: fixed register
        16'h9D61,   //  4: fixed register, clock divide off
        16'h9C30,   //  3: fixed register
        16'h9AE0,   //  2: fixed register
        16'h9803,   //  1: fixed register
        16'h4110    //  0: power up the transmitter
    };

endpackage

// File: rtl/hdmi_cfg_rom.sv
// rtl/hdmi_cfg_rom.sv - combinational index to {reg, value} lookup
//
// Purpose: isolates the configuration table from the sequencer FSM so the
//          table can be replaced without touching control logic.
// Ports:   index    - table entry number
//          reg_addr - register address of the entry (0 beyond the table)
//          reg_data - register value of the entry (0 beyond the table)
module hdmi_cfg_rom
    import hdmi_cfg_pkg::*;
(
    input  logic [7:0] index,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data
);

    logic [15:0] entry;

    always_comb begin
        entry = 16'h0000;
        if (index < 8'(CFG_TABLE_LEN)) begin
            entry = CFG_TABLE[{index, 4'b0000} +: 16];
        end
    end

    assign reg_addr = entry[15:8];
    assign reg_data = entry[7:0];

endmodule

// File: rtl/hdmi_cfg_sequencer.sv
// rtl/hdmi_cfg_sequencer.sv - HDMI transmitter I2C configuration sequencer
//
// Purpose: after start (or reset release + start) waits for power-up, then
//          writes every table entry through a valid/ready command and a
//          response handshake, retrying NACKed writes after a gap.
// Optional: HPD_REINIT_EN - a rising edge of the synchronized hdmi_tx_int in
//          DONE or FAIL restarts the table at entry 0 without power-up wait.
// Ports:   clock50      - 50 MHz clock
//          reset        - asynchronous active-high reset
//          start        - one-cycle pulse, starts/restarts the sequence
//          hdmi_tx_int  - asynchronous hot-plug/interrupt line
//          cmd_*        - write command to the I2C master (valid/ready)
//          rsp_valid    - one-cycle pulse, transaction finished
//          rsp_nack     - slave NACKed, qualified by rsp_valid
//          busy         - sequence in progress
//          ready_out    - all entries written
//          fail         - an entry ran out of retries
//          cur_index    - current or failing entry
module hdmi_cfg_sequencer
    import hdmi_cfg_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR         = DEFAULT_DEV_ADDR,
    parameter int         NUM_WRITES       = 16,
    parameter int         POWERUP_CYCLES   = 1000000,
    parameter int         MAX_RETRIES      = 3,
    parameter int         RETRY_GAP_CYCLES = 5000
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       start,
    input  logic       hdmi_tx_int,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_dev,
    output logic [7:0] cmd_reg,
    output logic [7:0] cmd_data,
    input  logic       rsp_valid,
    input  logic       rsp_nack,
    output logic       busy,
    output logic       ready_out,
    output logic       fail,
    output logic [7:0] cur_index
);

    localparam logic [31:0] PWR_LOAD    = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD    = 32'(RETRY_GAP_CYCLES - 1);
    localparam logic [7:0]  LAST_INDEX  = 8'(NUM_WRITES - 1);
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRIES);

    cfg_state_t  state;
    logic [31:0] wait_cnt;
    logic [7:0]  retry_cnt;
    logic        hpd_meta;
    logic        hpd_sync;
    logic        restart_hpd;
    logic [7:0]  rom_index;
    logic [7:0]  rom_reg;
    logic [7:0]  rom_data;

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            hpd_meta <= 1'b0;
            hpd_sync <= 1'b0;
        end else begin
            hpd_meta <= hdmi_tx_int;
            hpd_sync <= hpd_meta;
        end
    end

`ifdef HPD_REINIT_EN
    logic hpd_prev;

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            hpd_prev <= 1'b0;
        end else begin
            hpd_prev <= hpd_sync;
        end
    end

    assign restart_hpd = hpd_sync && !hpd_prev && (state == DONE || state == FAIL);
`else
    // Synchronized but not consumed in this build.
    logic hpd_unused;
    assign hpd_unused  = hpd_sync;
    assign restart_hpd = 1'b0;
`endif

    // The ROM is addressed with the index the FSM is about to issue, so the
    // command fields can be registered in the same edge that raises cmd_valid.
    always_comb begin
        rom_index = cur_index;
        if (restart_hpd || state == PWR_WAIT) begin
            rom_index = 8'd0;
        end else if (state == WAIT_RSP) begin
            rom_index = cur_index + 8'd1;
        end
    end

    hdmi_cfg_rom u_rom (
        .index    (rom_index),
        .reg_addr (rom_reg),
        .reg_data (rom_data)
    );

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 32'd0;
            retry_cnt <= 8'd0;
            cur_index <= 8'd0;
            cmd_valid <= 1'b0;
            cmd_dev   <= 8'd0;
            cmd_reg   <= 8'd0;
            cmd_data  <= 8'd0;
            busy      <= 1'b0;
            ready_out <= 1'b0;
            fail      <= 1'b0;
        end else if (start) begin
            // Restart from any state; an outstanding response of an aborted
            // write is dropped because rsp_valid only matters in WAIT_RSP.
            state     <= PWR_WAIT;
            wait_cnt  <= PWR_LOAD;
            retry_cnt <= 8'd0;
            cur_index <= 8'd0;
            cmd_valid <= 1'b0;
            busy      <= 1'b1;
            ready_out <= 1'b0;
            fail      <= 1'b0;
        end else if (restart_hpd) begin
            state     <= ISSUE;
            retry_cnt <= 8'd0;
            cur_index <= 8'd0;
            cmd_valid <= 1'b1;
            cmd_dev   <= DEV_ADDR;
            cmd_reg   <= rom_reg;
            cmd_data  <= rom_data;
            busy      <= 1'b1;
            ready_out <= 1'b0;
            fail      <= 1'b0;
        end else begin
            case (state)
                IDLE: ;

                PWR_WAIT: begin
                    if (wait_cnt == 32'd0) begin
                        state     <= ISSUE;
                        retry_cnt <= 8'd0;
                        cur_index <= 8'd0;
                        cmd_valid <= 1'b1;
                        cmd_dev   <= DEV_ADDR;
                        cmd_reg   <= rom_reg;
                        cmd_data  <= rom_data;
                    end else begin
                        wait_cnt <= wait_cnt - 32'd1;
                    end
                end

                ISSUE: begin
                    if (cmd_ready) begin
                        state     <= WAIT_RSP;
                        cmd_valid <= 1'b0;
                    end
                end

                WAIT_RSP: begin
                    if (rsp_valid) begin
                        if (!rsp_nack) begin
                            if (cur_index == LAST_INDEX) begin
                                state     <= DONE;
                                busy      <= 1'b0;
                                ready_out <= 1'b1;
                            end else begin
                                state     <= ISSUE;
                                cur_index <= cur_index + 8'd1;
                                retry_cnt <= 8'd0;
                                cmd_valid <= 1'b1;
                                cmd_dev   <= DEV_ADDR;
                                cmd_reg   <= rom_reg;
                                cmd_data  <= rom_data;
                            end
                        end else if (retry_cnt < RETRY_LIMIT) begin
                            state     <= GAP;
                            retry_cnt <= retry_cnt + 8'd1;
                            wait_cnt  <= GAP_LOAD;
                        end else begin
                            state <= FAIL;
                            busy  <= 1'b0;
                            fail  <= 1'b1;
                        end
                    end
                end

                GAP: begin
                    if (wait_cnt == 32'd0) begin
                        state     <= ISSUE;
                        cmd_valid <= 1'b1;
                        cmd_dev   <= DEV_ADDR;
                        cmd_reg   <= rom_reg;
                        cmd_data  <= rom_data;
                    end else begin
                        wait_cnt <= wait_cnt - 32'd1;
                    end
                end

                DONE: ;

                FAIL: ;

                default: begin
                    state     <= IDLE;
                    cmd_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// tb/tb_hdmi_cfg_sequencer.sv - self-checking bench for hdmi_cfg_sequencer
module tb_hdmi_cfg_sequencer;

    localparam int P_PWR   = 10;
    localparam int P_GAP   = 4;
    localparam int P_NUM   = 4;
    localparam int P_RETRY = 2;

    logic       clock50     = 1'b0;
    logic       reset       = 1'b1;
    logic       start       = 1'b0;
    logic       hdmi_tx_int = 1'b0;
    logic       cmd_ready   = 1'b0;
    logic       rsp_valid   = 1'b0;
    logic       rsp_nack    = 1'b0;
    logic       cmd_valid;
    logic [7:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       busy;
    logic       ready_out;
    logic       fail;
    logic [7:0] cur_index;

    int errors    = 0;
    int checks    = 0;
    int cmd_count = 0;

    int nack_entry = -1;
    int nack_times = 0;
    int rdy_fixed  = -1;
    bit rand_mode  = 1'b0;

    logic [15:0] exp_table [4] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30};

    hdmi_cfg_sequencer #(
        .DEV_ADDR         (8'h72),
        .NUM_WRITES       (P_NUM),
        .POWERUP_CYCLES   (P_PWR),
        .MAX_RETRIES      (P_RETRY),
        .RETRY_GAP_CYCLES (P_GAP)
    ) dut (
        .clock50     (clock50),
        .reset       (reset),
        .start       (start),
        .hdmi_tx_int (hdmi_tx_int),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_dev     (cmd_dev),
        .cmd_reg     (cmd_reg),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_nack    (rsp_nack),
        .busy        (busy),
        .ready_out   (ready_out),
        .fail        (fail),
        .cur_index   (cur_index)
    );

    always #5 clock50 = ~clock50;

    always @(posedge clock50) begin
        if (cmd_valid && cmd_ready) cmd_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock50);
        start = 1'b0;
    endtask

    task automatic wait_cmd(output int idle);
        idle = 0;
        while (!cmd_valid && idle < 200) begin
            idle++;
            @(negedge clock50);
        end
        if (!cmd_valid) chk("cmd_timeout", cmd_valid, 1);
    endtask

    task automatic handshake(input int idx);
        int         d;
        logic [7:0] r0;
        logic [7:0] v0;
        d  = (rdy_fixed >= 0) ? rdy_fixed : int'($urandom_range(0, 3));
        r0 = cmd_reg;
        v0 = cmd_data;
        chk("cmd_index", cur_index, idx);
        chk("busy_issue", busy, 1);
        repeat (d) @(negedge clock50);
        chk("cmd_stable", {cmd_reg, cmd_data}, {r0, v0});
        chk("cmd_valid_held", cmd_valid, 1);
        chk("cmd_dev", cmd_dev, 8'h72);
        chk("cmd_reg", cmd_reg, exp_table[idx][15:8]);
        chk("cmd_data", cmd_data, exp_table[idx][7:0]);
        cmd_ready = 1'b1;
        @(negedge clock50);
        cmd_ready = 1'b0;
        chk("cmd_valid_drop", cmd_valid, 0);
    endtask

    task automatic respond(input bit nack);
        repeat ($urandom_range(1, 5)) @(negedge clock50);
        rsp_valid = 1'b1;
        rsp_nack  = nack;
        @(negedge clock50);
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
    endtask

    // Reference: each entry gets one attempt plus up to P_RETRY retries;
    // a NACK is followed by P_GAP idle cycles, an ACK by none.
    task automatic drive_sequence(input int first_idle, input bit skip_first);
        int m_idx    = 0;
        int m_try    = 0;
        int idle     = 0;
        int gap_exp  = 0;
        int snap     = 0;
        bit nk       = 1'b0;
        bit finished = 1'b0;
        bit failed   = 1'b0;
        if (!skip_first) begin
            wait_cmd(idle);
            chk("first_cmd_latency", idle, first_idle);
        end
        while (!finished && !failed) begin
            handshake(m_idx);
            if (rand_mode) nk = ($urandom_range(0, 3) == 0);
            else           nk = (m_idx == nack_entry) && (m_try < nack_times);
            respond(nk);
            if (nk) begin
                m_try++;
                failed  = (m_try > P_RETRY);
                gap_exp = P_GAP;
            end else begin
                m_idx++;
                m_try    = 0;
                finished = (m_idx == P_NUM);
                gap_exp  = 0;
            end
            if (!finished && !failed) begin
                wait_cmd(idle);
                chk("gap_cycles", idle, gap_exp);
            end
        end
        chk("end_ready_out", ready_out, finished);
        chk("end_fail", fail, failed);
        chk("end_busy", busy, 0);
        if (failed) chk("fail_index", cur_index, m_idx);
        snap = cmd_count;
        repeat (20) @(negedge clock50);
        chk("no_extra_cmd", cmd_count, snap);
        chk("end_cmd_valid", cmd_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout, expected summary before 400000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idle;
        int snap;
        int seen_idle;
        bit seen;

        repeat (3) @(negedge clock50);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready_out", ready_out, 0);
        chk("rst_fail", fail, 0);
        chk("rst_cur_index", cur_index, 0);
        chk("rst_cmd_dev", cmd_dev, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock50);

        // Happy path, cmd_ready delayed 3 cycles.
        rdy_fixed = 3;
        snap = cmd_count;
        pulse_start();
        drive_sequence(P_PWR, 1'b0);
        chk("happy_cmd_count", cmd_count - snap, P_NUM);

        // Entry 2 NACKed twice then ACKed.
        rdy_fixed  = -1;
        nack_entry = 2;
        nack_times = 2;
        snap = cmd_count;
        pulse_start();
        drive_sequence(P_PWR, 1'b0);
        chk("retry_cmd_count", cmd_count - snap, P_NUM + 2);

        // Entry 1 NACKed on every attempt.
        nack_entry = 1;
        nack_times = 3;
        snap = cmd_count;
        pulse_start();
        drive_sequence(P_PWR, 1'b0);
        chk("fail_cmd_count", cmd_count - snap, 4);

        // Restart during WAIT_RSP of entry 2, then a stray response.
        nack_entry = -1;
        nack_times = 0;
        pulse_start();
        chk("restart_fail_clr", fail, 0);
        wait_cmd(idle);
        chk("restart_pwr_wait", idle, P_PWR);
        handshake(0);
        respond(1'b0);
        wait_cmd(idle);
        handshake(1);
        respond(1'b0);
        wait_cmd(idle);
        handshake(2);
        start = 1'b1;
        @(negedge clock50);
        start     = 1'b0;
        rsp_valid = 1'b1;
        rsp_nack  = 1'b0;
        chk("abort_busy", busy, 1);
        chk("abort_index", cur_index, 0);
        chk("abort_cmd_valid", cmd_valid, 0);
        @(negedge clock50);
        rsp_valid = 1'b0;
        drive_sequence(P_PWR - 1, 1'b0);

        // Randomized NACK pattern and handshake timing.
        rand_mode = 1'b1;
        repeat (4) begin
            pulse_start();
            drive_sequence(P_PWR, 1'b0);
        end
        rand_mode = 1'b0;

        // Asynchronous reset while entry 2 is being offered.
        pulse_start();
        wait_cmd(idle);
        handshake(0);
        respond(1'b0);
        wait_cmd(idle);
        handshake(1);
        respond(1'b0);
        wait_cmd(idle);
        chk("pre_rst_index", cur_index, 2);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_cmd_valid", cmd_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_index", cur_index, 0);
        @(negedge clock50);
        reset = 1'b0;
        snap  = cmd_count;
        repeat (30) @(negedge clock50);
        chk("post_rst_no_cmd", cmd_count, snap);
        chk("post_rst_idle", busy, 0);

        // Hot-plug after DONE.
        pulse_start();
        drive_sequence(P_PWR, 1'b0);
        snap        = cmd_count;
        hdmi_tx_int = 1'b1;
        seen        = 1'b0;
        seen_idle   = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock50);
            if (!seen) begin
                if (cmd_valid) seen = 1'b1;
                else           seen_idle++;
            end
        end
        hdmi_tx_int = 1'b0;
`ifdef HPD_REINIT_EN
        chk("hpd_reissue", cmd_valid, 1);
        chk("hpd_within_4", (seen_idle <= 4), 1);
        chk("hpd_ready_clr", ready_out, 0);
        drive_sequence(0, 1'b1);
`else
        repeat (20) @(negedge clock50);
        chk("hpd_ignored_cmds", cmd_count, snap);
        chk("hpd_ignored_ready", ready_out, 1);
        chk("hpd_ignored_busy", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
